// File: rtl/alu_pkg.sv
// alu_pkg: types shared by the RX, decode and ALU stages
package alu_pkg;
  typedef enum logic [3:0] {
    OPC_NOP, OPC_ADD, OPC_SUB, OPC_MUL, OPC_AND, OPC_OR,
    OPC_XOR, OPC_SHL, OPC_SHR, OPC_DOT, OPC_CMP
  } opcode_e;
  localparam logic [3:0] OPC_MAX_LEGAL = 4'hA;
  typedef enum logic [1:0] {ERR_NONE, ERR_ILLEGAL, ERR_TIMEOUT} err_code_e;
  typedef enum logic [1:0] {IDLE, DECODE, ISSUE, WAIT} dec_state_e;
endpackage

// File: rtl/decode_timeout.sv
// decode_timeout: 8-bit loadable down-counter; zero flags the decrement that lands on zero
module decode_timeout (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       dec,
  input  logic [7:0] load_val,
  output logic       zero
);
  logic [7:0] count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else count <= load ? load_val : (dec && count != '0) ? count - 8'd1 : count;
  assign zero = dec && count == 8'd1;
endmodule

// File: rtl/decode.sv
// decode: captures RX instructions, validates the opcode and issues one ALU command per instruction
module decode
  import alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] op,
  input  logic [7:0] a1,
  input  logic [7:0] a2,
  input  logic [7:0] b1,
  input  logic [7:0] b2,
  input  logic       rx_valid,
  output logic       alu_ready,
  output logic       alu_start,
  output logic [3:0] alu_op,
  output logic [3:0] alu_flags,
  output logic [7:0] opa1,
  output logic [7:0] opa2,
  output logic [7:0] opb1,
  output logic [7:0] opb2,
  input  logic       alu_done,
  output logic       dec_err,
  output logic [1:0] err_code,
  output logic       busy
);
  dec_state_e state, state_nx;
  logic consumed, capture, illegal, expire;
  assign capture   = state == IDLE && rx_valid && !consumed;
  assign illegal   = alu_op > OPC_MAX_LEGAL;
  assign alu_ready = state == IDLE;
  assign busy      = !alu_ready;
  assign alu_start = state == ISSUE;
  // alu_done gates the decrement, so a done on the expiring cycle wins over the timeout
  decode_timeout u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == ISSUE),
    .dec      (state == WAIT && !alu_done),
    .load_val (8'(TIMEOUT_CYCLES)),
    .zero     (expire)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = capture ? DECODE : IDLE;
      DECODE:  state_nx = (alu_op == OPC_NOP || illegal) ? IDLE : ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = (alu_done || expire) ? IDLE : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  // rx_valid stays high after capture; consumed masks it until RX drops the level
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      consumed  <= 1'b0;
      alu_op    <= '0;
      alu_flags <= '0;
      opa1      <= '0;
      opa2      <= '0;
      opb1      <= '0;
      opb2      <= '0;
      dec_err   <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      state    <= state_nx;
      consumed <= rx_valid && (capture || consumed);
      if (capture) begin
        alu_op    <= op[3:0];
        alu_flags <= op[7:4];
        opa1      <= a1;
        opa2      <= a2;
        opb1      <= b1;
        opb2      <= b2;
        dec_err   <= 1'b0;
        err_code  <= ERR_NONE;
      end else if ((state == DECODE && illegal) || (state == WAIT && expire)) begin
        dec_err  <= 1'b1;
        err_code <= illegal ? ERR_ILLEGAL : ERR_TIMEOUT;
      end
    end
endmodule

// File: doc/decode.md
Name: decode

Overview:
- Decode stage directly downstream of the SPI RX stage and upstream of the ALU.
- Captures each completed 40-bit instruction (op, a1, a2, b1, b2) on rx_valid and validates the opcode.
- Issues one registered command to the ALU with an alu_start/alu_done handshake.
- Drives alu_ready back to RX so a new instruction is accepted only when this stage is idle.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in WAIT for alu_done before abort; legal range 1..255; 8-bit counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- op  input  8  from RX; [3:0] opcode, [7:4] flags
- a1, a2, b1, b2  input  8 each  operands from RX
- rx_valid  input  1  instruction-complete level from RX
- alu_ready  output  1  high only in IDLE; returned to RX
- alu_start  output  1  one-cycle command strobe to ALU
- alu_op  output  4  decoded opcode (opcode_e)
- alu_flags  output  4  op[7:4], registered
- opa1, opa2, opb1, opb2  output  8 each  registered operands
- alu_done  input  1  ALU completion pulse
- dec_err  output  1  sticky error, cleared on next capture
- err_code  output  2  0 none, 1 illegal opcode, 2 ALU timeout
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n low): state = IDLE. alu_ready = 1. alu_start = 0. alu_op, alu_flags, opa*, opb* = 0. dec_err = 0. err_code = 0. busy = 0. consumed = 0. timeout counter = 0.
- Reset asserted mid-operation aborts any instruction immediately, with no alu_start glitch.
- Consumed flag:
  - RX holds rx_valid high while alu_ready is low, so the level is stale after capture.
  - consumed sets on capture and clears on any cycle with rx_valid = 0.
- Capture condition: state == IDLE && rx_valid && !consumed.
- System constraint: rx_valid staying high continuously across two instructions is not supported. SPI byte pacing guarantees this never happens.
- States and transitions:
  - IDLE: on capture, register op/operands, clear dec_err/err_code, go to DECODE. alu_ready drops the next cycle.
  - DECODE: 1 cycle. Opcode 0x0 (NOP) goes to IDLE with no start and no error. 0x1–0xA go to ISSUE. 0xB–0xF set dec_err = 1, err_code = 1, and go to IDLE.
  - ISSUE: alu_start = 1 for exactly one cycle; load timeout counter = TIMEOUT_CYCLES; go to WAIT.
  - WAIT: alu_done goes to IDLE. Otherwise decrement the counter; if it reaches 0, set dec_err = 1, err_code = 2, and go to IDLE.
  - alu_done arriving on the same cycle the counter hits 0 counts as done: no error.
- Opcodes (opcode_e): 0 NOP, 1 ADD, 2 SUB, 3 MUL, 4 AND, 5 OR, 6 XOR, 7 SHL, 8 SHR, 9 DOT, A CMP.
- alu_op, alu_flags, opa*, opb* are stable from DECODE until the next capture; the ALU may sample them any time after alu_start.
- alu_done seen outside WAIT is ignored.
- Latency:
  - capture → alu_start = 2 cycles.
  - alu_done → alu_ready high = 1 cycle.
  - Minimum IDLE-to-IDLE cycle = 4 cycles (capture, DECODE, ISSUE, WAIT with immediate done).

Decomposition:
- Shared package alu_pkg holds:
  - opcode_e (4-bit enum above)
  - OPC_MAX_LEGAL = 4'hA
  - err_code_e (ERR_NONE, ERR_ILLEGAL, ERR_TIMEOUT)
  - dec_state_e (IDLE, DECODE, ISSUE, WAIT)
- RX, decode and ALU all import alu_pkg.
- One sub-module is natural: decode_timeout, an 8-bit loadable down-counter with a zero flag. Everything else stays flat in decode.

Test Plan:
- Reset then idle: alu_ready = 1, busy = 0, alu_start never asserted over 50 cycles.
- rx_valid with op = 8'h31, a1 = 5, a2 = 6, b1 = 7, b2 = 8, held high: alu_start pulses exactly once, 2 cycles after capture, with alu_op = ADD, alu_flags = 4'h3, opa1/opa2/opb1/opb2 = 5/6/7/8. alu_done 3 cycles later → alu_ready = 1 the next cycle. rx_valid still high at that point causes no second capture.
- op = 8'h0F: no alu_start; dec_err = 1, err_code = 1, back in IDLE 2 cycles after capture. A following op = 8'h02 clears dec_err on capture.
- op = 8'h00 (NOP): returns to IDLE with no alu_start and dec_err = 0.
- TIMEOUT_CYCLES = 4, op = 8'h03, alu_done never asserted: WAIT lasts 4 cycles, then dec_err = 1, err_code = 2, alu_ready = 1. A late alu_done is ignored.
- rst_n pulsed low during WAIT: all outputs return to reset values asynchronously; no alu_start after release until a new rx_valid rising-level capture.
